// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a single-port synchronous-read data memory
// between the processor (port 0) and a secondary master (port 1).
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | sample requests, pick a winner, load memory command
//   ACCESS | mem_en and winner's gnt high; write ends here
//   RESP   | read data on mem_rdata, winner's rvalid high
module dmem_arbiter #(
    parameter int AW = 16,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t        state;
    logic          win;
    logic          last;
    logic          we_q;
    logic [DW-1:0] rdata0_q;
    logic [DW-1:0] rdata1_q;
    logic          pick1;

    // On a tie the port that was not served last wins.
    assign pick1 = req1 & (~req0 | ~last);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            win       <= 1'b0;
            last      <= 1'b1;
            we_q      <= 1'b0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
        end else begin
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            mem_en  <= 1'b0;
            mem_we  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        win       <= pick1;
                        we_q      <= pick1 ? we1 : we0;
                        mem_en    <= 1'b1;
                        mem_we    <= pick1 ? we1 : we0;
                        mem_addr  <= pick1 ? addr1 : addr0;
                        mem_wdata <= pick1 ? wdata1 : wdata0;
                        gnt0      <= ~pick1;
                        gnt1      <= pick1;
                        busy      <= 1'b1;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    last <= win;
                    if (we_q) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        rvalid0 <= ~win;
                        rvalid1 <= win;
                        state   <= RESP;
                    end
                end
                RESP: begin
                    if (win) rdata1_q <= mem_rdata;
                    else     rdata0_q <= mem_rdata;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // The memory only presents read data during RESP, so the live value is
    // forwarded while rvalid is high and the captured copy is held afterwards.
    assign rdata0 = rvalid0 ? mem_rdata : rdata0_q;
    assign rdata1 = rvalid1 ? mem_rdata : rdata1_q;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter sharing the single-port, synchronous-read 16-bit data memory between the processor (port 0) and a secondary master such as a program/data loader or debug engine (port 1). It owns all memory control signals, runs a fixed 3-state access sequence, and picks between requesters round-robin. Each requester sees a req/gnt/rvalid handshake. The arbiter sits between the processor's memory port and the data memory in the top level.

## Interface
- AW, 16, address width
- DW, 16, data width
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- req0, req1  input  1  access request from port 0 / port 1
- we0, we1  input  1  1 = write, 0 = read
- addr0, addr1  input  AW  access address
- wdata0, wdata1  input  DW  write data
- gnt0, gnt1  output  1  one-cycle pulse: access issued to memory
- rvalid0, rvalid1  output  1  one-cycle pulse: read data valid on rdata0/rdata1
- rdata0, rdata1  output  DW  read data, held until next read completes on that port
- mem_en  output  1  memory access strobe
- mem_we  output  1  memory write enable, only meaningful with mem_en
- mem_addr  output  AW  memory address
- mem_wdata  output  DW  memory write data
- mem_rdata  input  DW  memory read data, valid the cycle after mem_en with mem_we=0
- busy  output  1  high whenever state is not IDLE

## Operation
- States: IDLE, ACCESS, RESP. Reset state is IDLE.
- IDLE:
  - If neither req is high, stay in IDLE.
  - If exactly one req is high, that port wins.
  - If both are high, the port that is not `last` wins.
  - On a win, register the winner id, we, addr and wdata, then go to ACCESS.
- ACCESS (exactly one cycle):
  - mem_en=1; mem_we, mem_addr and mem_wdata come from the registered values.
  - gnt of the winner is 1.
  - `last` is set to the winner.
  - Write: go to IDLE. Read: go to RESP.
- RESP (exactly one cycle):
  - Capture mem_rdata into the winner's rdata register and pulse that port's rvalid.
  - Go to IDLE.
- Requester rules:
  - req, we, addr and wdata stay stable from assertion until gnt is seen.
  - A requester that is done drops req no later than the cycle after gnt.
  - A req still high in IDLE after gnt is a new request, which allows back-to-back accesses.
- Request inputs are ignored in ACCESS and RESP. They are only sampled in IDLE.
- Round-robin pointer `last` resets to 1, so port 0 wins the first tie.
- Outputs are registered. mem_en, mem_we, gnt and rvalid are never high outside the states listed above.
- mem_addr and mem_wdata hold their last value while idle.
- Reset values: gnt0/1=0, rvalid0/1=0, rdata0/1=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0.
- Reset mid-access: all state and outputs clear asynchronously. The pending read returns no rvalid. There is no retry; the requester re-issues after reset.
- Both ports requesting the same address in the same cycle is serialized by round-robin. There is no merging.

## Timing
- Cycle T: req sampled high in IDLE.
- T+1: ACCESS; mem_en and gnt high.
- T+2, read: RESP; rvalid high with rdata.
- Latency:
  - Read: 2 cycles from request sample to rvalid.
  - Write: 1 cycle from request sample to gnt and memory write.
- Throughput with req held continuously:
  - One write every 2 cycles.
  - One read every 3 cycles.
  - Both ports requesting: grants alternate 0,1,0,1.
- busy is high in ACCESS and RESP.
- Worst-case wait for a held request: one access by the other port, i.e. at most 3 cycles before its own ACCESS.

## Test plan
- Reset: hold reset=0 with req0=req1=1. All outputs stay 0 and busy=0. Release reset with req0=req1=1; gnt0 pulses first at T+1.
- Single write then read on port 0:
  - Write 0x1234 to addr 0x0010: mem_en=1, mem_we=1, mem_addr=0x0010, mem_wdata=0x1234, gnt0=1 at T+1.
  - Read addr 0x0010 with the memory model returning 0x1234: rvalid0=1 and rdata0=0x1234 at T+2, rvalid1 stays 0.
- Contention: req0 and req1 held high with reads to 0x0001 and 0x0002. Grants alternate gnt0, gnt1, gnt0, gnt1, one every 3 cycles. Each rvalid goes to the correct port with the correct data.
- Back-to-back writes: req1 held high with the address incrementing on each gnt1. gnt1 pulses every 2 cycles and mem_addr steps 0,1,2,3.
- Reset mid-read: assert reset=0 during ACCESS of a port-1 read. mem_en drops immediately, no rvalid1 appears, and state is IDLE after release.
- Stability: port 0 holds its request while port 1 is being served. Port 0's addr is issued unchanged in the next ACCESS. rdata0 keeps its previous value until rvalid0.
